// File: rtl/mantissa_seq_multiplier.sv
// mantissa_seq_multiplier
// Radix-2 shift-add multiplier for floating-point significands (hidden bit
// included). One multiplier bit is consumed per clock; operands and product
// use valid/ready handshakes.
// Optional build macro: MUL_EARLY_TERMINATION_EN. When it is defined, the
// calculation stops as soon as no set multiplier bits remain.
module mantissa_seq_multiplier #(
  parameter int MULTIPLICAND_LENGTH = 24,
  parameter int MULTIPLIER_LENGTH   = 24,
  parameter int PRODUCT_LENGTH      = 48
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MULTIPLICAND_LENGTH-1:0] multiplicand,
  input  logic [MULTIPLIER_LENGTH-1:0]   multiplier,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PRODUCT_LENGTH-1:0]      product,
  output logic                           busy
);

  localparam int CW = $clog2(MULTIPLIER_LENGTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(MULTIPLIER_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic [PRODUCT_LENGTH-1:0]       mcand_r;
  logic [MULTIPLIER_LENGTH-1:0]    mplier_r;
  logic [PRODUCT_LENGTH-1:0]       acc;
  logic [PRODUCT_LENGTH-1:0]       acc_sum;
  logic [PRODUCT_LENGTH-1:0]       product_r;
  logic [CW-1:0]                   count;
  logic                            accept;
  logic                            out_fire;
  logic                            last_step;

  // Handshake and status outputs come straight from the state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC) || (state == DONE);
  assign product   = product_r;

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Partial-product sum for the current multiplier bit.
  assign acc_sum = acc + (mplier_r[0] ? mcand_r : '0);

`ifdef MUL_EARLY_TERMINATION_EN
  // Finish after the last multiplier bit or once no set bits remain above bit 0.
  assign last_step = (count == LAST_COUNT) || ((mplier_r >> 1) == '0);
`else
  // Always walk every multiplier bit.
  assign last_step = (count == LAST_COUNT);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)    state_next = CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: if (out_fire)  state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift-add while calculating,
  // and latch the final sum into the held product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r   <= '0;
      mplier_r  <= '0;
      acc       <= '0;
      count     <= '0;
      product_r <= '0;
    end else if (accept) begin
      mcand_r  <= PRODUCT_LENGTH'(multiplicand);
      mplier_r <= multiplier;
      acc      <= '0;
      count    <= '0;
    end else if (state == CALC) begin
      acc      <= acc_sum;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      count    <= count + CW'(1);
      if (last_step) begin
        product_r <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mantissa_seq_multiplier.sv
// tb_mantissa_seq_multiplier
// Directed and randomized transactions against a plain-arithmetic model of
// the significand product and its expected latency.
module tb_mantissa_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] multiplicand;
  logic [23:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;
  logic        busy;

  int check_count = 0;
  int pass_count  = 0;

  mantissa_seq_multiplier #(
    .MULTIPLICAND_LENGTH(24),
    .MULTIPLIER_LENGTH  (24),
    .PRODUCT_LENGTH     (48)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: exact unsigned multiplication.
  function automatic logic [47:0] refProduct(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] wa;
    logic [47:0] wb;
    wa = {24'd0, a};
    wb = {24'd0, b};
    return wa * wb;
  endfunction

  // Reference latency in clocks from the accepting edge to out_valid.
  function automatic int refLatency(input logic [23:0] b);
    int n;
    n = 24;
`ifdef MUL_EARLY_TERMINATION_EN
    n = 1;
    for (int i = 0; i < 24; i++) begin
      if (b[i]) n = i + 1;
    end
`endif
    return n;
  endfunction

  // One comparison: counted, asserted, reported on failure.
  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Waits (bounded) for out_valid; called at a negedge, returns at a negedge.
  task automatic waitOutput(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Full transaction with optional output stall cycles.
  task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b, input int stall);
    int lat;
    logic [47:0] exp_p;
    exp_p = refProduct(a, b);
    @(negedge clk);
    checkOutput("in_ready_idle", {47'd0, in_ready}, 48'd1);
    in_valid     = 1'b1;
    multiplicand = a;
    multiplier   = b;
    out_ready    = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid     = 1'b0;
    multiplicand = 24'($urandom);
    multiplier   = 24'($urandom);
    checkOutput("busy_calc", {47'd0, busy}, 48'd1);
    checkOutput("in_ready_calc", {47'd0, in_ready}, 48'd0);
    waitOutput(lat);
    checkOutput("latency", 48'(lat), 48'(refLatency(b)));
    checkOutput("product", product, exp_p);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall_out_valid", {47'd0, out_valid}, 48'd1);
      checkOutput("stall_product", product, exp_p);
      checkOutput("stall_in_ready", {47'd0, in_ready}, 48'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("out_valid_drop", {47'd0, out_valid}, 48'd0);
    checkOutput("in_ready_after", {47'd0, in_ready}, 48'd1);
    checkOutput("busy_after", {47'd0, busy}, 48'd0);
    checkOutput("product_held", product, exp_p);
  endtask

  // Linear sequence of directed steps followed by random operands.
  initial begin
    int lat;
    logic [23:0] a1, b1, a2, b2, ra, rb;
    bit seen_valid;

    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", {47'd0, in_ready}, 48'd1);
    checkOutput("rst_out_valid", {47'd0, out_valid}, 48'd0);
    checkOutput("rst_busy", {47'd0, busy}, 48'd0);
    checkOutput("rst_product", product, 48'd0);
    rst = 1'b0;

    // Directed operand pairs, including the largest operands and a short multiplier.
    applyStimulus(24'h800000, 24'h800000, 0);
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 0);
    applyStimulus(24'hA15800, 24'h000003, 0);
    applyStimulus(24'h123456, 24'h000000, 0);
    applyStimulus(24'h000000, 24'h654321, 0);
    applyStimulus(24'hC0FFEE, 24'h000001, 0);

    // Output backpressure for five clocks.
    applyStimulus(24'h9ABCDE, 24'h5A5A5A, 5);

    // in_valid held through CALC with different operands.
    a1 = 24'hDEAD12; b1 = 24'h00BEEF;
    a2 = 24'h13579B; b2 = 24'hF00001;
    @(negedge clk);
    in_valid = 1'b1; multiplicand = a1; multiplier = b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    multiplicand = a2; multiplier = b2;
    waitOutput(lat);
    checkOutput("held_valid_latency1", 48'(lat), 48'(refLatency(b1)));
    checkOutput("held_valid_product1", product, refProduct(a1, b1));
    @(posedge clk);
    @(negedge clk);
    checkOutput("held_valid_idle", {47'd0, in_ready}, 48'd1);
    checkOutput("held_valid_drop", {47'd0, out_valid}, 48'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("held_valid_busy2", {47'd0, busy}, 48'd1);
    waitOutput(lat);
    checkOutput("held_valid_latency2", 48'(lat), 48'(refLatency(b2)));
    checkOutput("held_valid_product2", product, refProduct(a2, b2));
    @(posedge clk);
    @(negedge clk);
    checkOutput("held_valid_done2", {47'd0, out_valid}, 48'd0);

    // Reset in the middle of a calculation.
    @(negedge clk);
    in_valid = 1'b1; multiplicand = 24'h851230; multiplier = 24'h800953;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_in_ready", {47'd0, in_ready}, 48'd1);
    checkOutput("abort_out_valid", {47'd0, out_valid}, 48'd0);
    checkOutput("abort_busy", {47'd0, busy}, 48'd0);
    checkOutput("abort_product", product, 48'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid || busy) seen_valid = 1'b1;
    end
    checkOutput("abort_no_output", {47'd0, seen_valid}, 48'd0);
    applyStimulus(24'd2, 24'd3, 0);

    // Random operands with random multiplier widths and output stalls.
    for (int n = 0; n < 12; n++) begin
      ra = 24'($urandom);
      rb = 24'($urandom) >> $urandom_range(0, 23);
      applyStimulus(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
